// File: rtl/bintobcd_autorange_if.sv
// Request/result bundle between the measurement core and the binary-to-BCD auto-ranging converter.
interface bintobcd_autorange_if #(
    parameter int BIN_W       = 32,
    parameter int DISP_DIGITS = 4
);
    logic                     i_start;
    logic [BIN_W-1:0]         i_bin;
    logic                     i_autorange;
    logic                     o_ready;
    logic                     o_done;
    logic                     o_overflow;
    logic [4*DISP_DIGITS-1:0] o_bcd;
    logic [DISP_DIGITS-1:0]   o_dp;
    logic [DISP_DIGITS-1:0]   o_blank;

    modport master (
        output i_start, i_bin, i_autorange,
        input  o_ready, o_done, o_overflow, o_bcd, o_dp, o_blank
    );

    modport slave (
        input  i_start, i_bin, i_autorange,
        output o_ready, o_done, o_overflow, o_bcd, o_dp, o_blank
    );
endinterface

// File: rtl/bintobcd_autorange.sv
// Sequential double-dabble binary-to-BCD converter with an auto-ranging display window and moving dp.
// Define BINTOBCD_BLANK_EN to generate the leading-zero blank mask; otherwise o_blank is tied to 0.
module bintobcd_autorange #(
    parameter int          BIN_W       = 32,
    parameter int          BCD_DIGITS  = 7,
    parameter int          DISP_DIGITS = 4,
    parameter logic [63:0] MAX_IN      = 64'd9_999_999
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    bintobcd_autorange_if.slave  bus
);
    localparam int BCD_W  = 4 * BCD_DIGITS;
    localparam int DISP_W = 4 * DISP_DIGITS;
    localparam int WIN    = BCD_DIGITS - DISP_DIGITS;
    localparam int IDX_W  = $clog2(BIN_W + 1);
    localparam int CNT_W  = $clog2(BCD_DIGITS + 1);
    localparam logic [BIN_W-1:0] MAX_IN_W = BIN_W'(MAX_IN);

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_WINDOW, S_DONE, S_OVF} state_t;

    state_t                 state_q, state_d;
    logic [BCD_W-1:0]       bcd_q, bcd_adj;
    logic [BIN_W-1:0]       bin_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DISP_DIGITS-1:0] dp_q;
    logic [DISP_W-1:0]      bcd_o;
    logic [DISP_DIGITS-1:0] dp_o, blank_o, blank_d;
    logic                   top_zero;

    assign top_zero = (bcd_q[BCD_W-1 -: 4] == 4'd0);

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        bus.o_ready     = 1'b0;
        bus.o_done      = 1'b0;
        bus.o_overflow  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_start) state_d = (bus.i_bin > MAX_IN_W) ? S_OVF : S_SHIFT;
            end
            S_SHIFT:  if (idx_q == '0) state_d = S_WINDOW;
            S_WINDOW: if (cnt_q == '0 || !top_zero || !bus.i_autorange) state_d = S_DONE;
            S_DONE: begin
                bus.o_done = 1'b1;
                state_d    = S_IDLE;
            end
            S_OVF: begin
                bus.o_done     = 1'b1;
                bus.o_overflow = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Double-dabble correction: any digit of 5 or more becomes >= 8 and carries on the next shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (bcd_q[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

`ifdef BINTOBCD_BLANK_EN
    // Blank a digit while everything to its left is zero and the dp has not yet been passed.
    always_comb begin
        logic lz, past_dp;
        blank_d = '0;
        lz      = 1'b1;
        past_dp = 1'b0;
        for (int k = DISP_DIGITS - 1; k >= 0; k--) begin
            if (dp_q[k]) past_dp = 1'b1;
            lz         = lz & (bcd_q[BCD_W-DISP_W+4*k +: 4] == 4'd0);
            blank_d[k] = lz & ~past_dp;
        end
    end
`else
    assign blank_d = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            dp_q    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: if (bus.i_start) begin
                    bin_q <= bus.i_bin;
                    bcd_q <= '0;
                    idx_q <= IDX_W'(BIN_W);
                end
                S_SHIFT: begin
                    if (idx_q != '0) begin
                        {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                        idx_q          <= idx_q - IDX_W'(1);
                    end else begin
                        dp_q  <= DISP_DIGITS'(1);
                        cnt_q <= CNT_W'(WIN);
                    end
                end
                S_WINDOW: if (state_d == S_WINDOW) begin
                    bcd_q <= bcd_q << 4;
                    dp_q  <= dp_q << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Display registers change only when a result is published, never during conversion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bcd_o   <= '0;
            dp_o    <= '0;
            blank_o <= '0;
        end else if (state_q == S_IDLE && state_d == S_OVF) begin
            bcd_o   <= {DISP_DIGITS{4'h9}};
            dp_o    <= DISP_DIGITS'(1);
            blank_o <= '0;
        end else if (state_q == S_WINDOW && state_d == S_DONE) begin
            bcd_o   <= bcd_q[BCD_W-1 -: DISP_W];
            dp_o    <= dp_q;
            blank_o <= blank_d;
        end
    end

    assign bus.o_bcd   = bcd_o;
    assign bus.o_dp    = dp_o;
    assign bus.o_blank = blank_o;
endmodule
